// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: two half adders plus one carry flop form the full-adder cell, LSB first.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the `sub` input).

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               c_q, c_d, cout_q, cout_d;
  logic               h1_s, h1_c, h2_s, h2_c, sub_w;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  half_adder u_h1 (.a_i(a_sr_q[0]), .b_i(b_sr_q[0]), .sum_o(h1_s), .carry_o(h1_c));
  half_adder u_h2 (.a_i(h1_s),      .b_i(c_q),       .sum_o(h2_s), .carry_o(h2_c));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        // Subtract is a + ~b + 1: invert b on capture and seed the carry with 1.
        a_sr_d  = a;
        b_sr_d  = b ^ {WIDTH{sub_w}};
        c_d     = sub_w;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d  = {h2_s, sum_q[WIDTH-1:1]};
        c_d    = h1_c | h2_c;
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = h1_c | h2_c;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance for function/backpressure/reset, WIDTH=2 for exhaustive sweep.
`timescale 1ns/1ps
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       iv8 = 0, ir8, ov8, or8 = 0, co8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  logic       iv2 = 0, ir2, ov2, or2 = 0, co2;
  logic [1:0] a2 = 0, b2 = 0, s2;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub8 = 0, sub2 = 0;
`endif

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub8),
`endif
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carry_out(co8));

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub2),
`endif
    .out_valid(ov2), .out_ready(or2), .sum(s2), .carry_out(co2));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 transaction; with stall, hold off out_ready 5 cycles and keep junk on a/b with in_valid high.
  task automatic go8(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic sb,
                     input bit stall, input logic [7:0] es, input logic ec);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, ir8, 1);
    a8 = av; b8 = bv; iv8 = 1; or8 = !stall;
`ifdef SERIAL_ADDER_SUB_EN
    sub8 = sb;
`else
    if (sb) $display("note: sub requested in add-only build");
`endif
    @(negedge clk);
    chk({tag, "_busy"}, ir8, 0);
    if (stall) begin a8 = ~av; b8 = ~bv; end else iv8 = 0;
    lat = 0;
    while (!ov8 && lat < 40) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, s8, es);
    chk({tag, "_co"}, co8, ec);
    if (stall) begin
      repeat (5) begin
        @(negedge clk);
        chk({tag, "_hold_ov"}, ov8, 1);
        chk({tag, "_hold_sum"}, {s8, co8}, {es, ec});
      end
      iv8 = 0; or8 = 1;
    end
    @(negedge clk);
    chk({tag, "_idle_rdy"}, ir8, 1);
    chk({tag, "_idle_ov"}, ov8, 0);
    chk({tag, "_idle_sum"}, {s8, co8}, {es, ec});
  endtask

  initial begin
    int n, t, tprev;
    logic [1:0] av, bv;
    logic [2:0] ref3;
    #12;
    chk("rst_rdy", ir8, 1);
    chk("rst_ov", ov8, 0);
    chk("rst_out", {s8, co8}, 9'h0);
    @(negedge clk); rst_n = 1;

    go8("add3_5", 8'h03, 8'h05, 0, 0, 8'h08, 0);
    go8("ff_01",  8'hFF, 8'h01, 0, 0, 8'h00, 1);
    go8("ff_ff",  8'hFF, 8'hFF, 0, 0, 8'hFE, 1);
    go8("bp",     8'h5A, 8'hC3, 0, 1, 8'h1D, 1);

    // Reset while cnt==3: outputs must clear before any further clock edge.
    @(negedge clk); a8 = 8'h77; b8 = 8'h11; iv8 = 1; or8 = 1;
    @(negedge clk); iv8 = 0;
    repeat (3) @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_ov", ov8, 0);
    chk("mid_rst_sum", s8, 0);
    chk("mid_rst_rdy", ir8, 1);
    @(negedge clk); rst_n = 1;
    go8("post_rst", 8'h10, 8'h20, 0, 0, 8'h30, 0);

`ifdef SERIAL_ADDER_SUB_EN
    go8("sub5_3", 8'h05, 8'h03, 1, 0, 8'h02, 1);
    go8("sub3_5", 8'h03, 8'h05, 1, 0, 8'hFE, 0);
    go8("add_s0", 8'h03, 8'h05, 0, 0, 8'h08, 0);
`endif

    // WIDTH=2 sweep with in_valid held high throughout.
    @(negedge clk); iv2 = 1; or2 = 1;
    tprev = 0;
    for (int i = 0; i < 16; i++) begin
      av = 2'(i >> 2); bv = 2'(i & 3);
      n = 0;
      while (!ir2 && n < 20) begin @(negedge clk); n++; end
      chk("w2_rdy", ir2, 1);
      t = cyc;
      if (i >= 2) chk("w2_ii", t - tprev, 4);
      tprev = t;
      a2 = av; b2 = bv;
      @(negedge clk);
      n = 0;
      while (!ov2 && n < 20) begin @(negedge clk); n++; end
      ref3 = {1'b0, av} + {1'b0, bv};
      chk($sformatf("w2_%0d_%0d", av, bv), {co2, s2}, ref3);
      @(negedge clk);
    end
    iv2 = 0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
